// File: rtl/rom_read_arbiter_pkg.sv
// Shared constants and types for the two-port ROM read arbiter.
package rom_arb_pkg;

  localparam int unsigned NUM_PORTS      = 2;
  localparam int unsigned PORT_CPU       = 0;
  localparam int unsigned PORT_AUX       = 1;
  localparam int unsigned ROM_RD_LATENCY = 1;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Which port wins the next tie; round-robin hands the tie to the port not granted last.
  typedef enum logic {
    PREF_CPU = 1'b0,
    PREF_AUX = 1'b1
  } rr_pref_e;

  function automatic rr_pref_e pref_after_grant(input logic [NUM_PORTS-1:0] gnt);
    return gnt[PORT_CPU] ? PREF_AUX : PREF_CPU;
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of the ROM read arbiter: request/address in, grant/valid/data out per port.
interface rom_read_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  req0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  modport master (
    output req0, addr0, req1, addr1,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
  );

  modport slave (
    input  req0, addr0, req1, addr1,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
  );

endinterface

// File: rtl/rom_read_arbiter_arb.sv
// 2-way arbiter: combinational one-hot grant, round-robin tie pointer or fixed port-0 priority.
module rr_arbiter2
  import rom_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  rr_pref_e pref_q;
  rr_pref_e pref_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref_q <= PREF_CPU;
    end else begin
      pref_q <= pref_d;
    end
  end

  // rst_n gates the grant so nothing is offered while reset is asserted.
  always_comb begin
    gnt = '0;
    if (rst_n && en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          if (FIXED_PRIO == ARB_FIXED || pref_q == PREF_CPU) begin
            gnt = 2'b01;
          end else begin
            gnt = 2'b10;
          end
        end
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    pref_d = pref_q;
    if (|gnt) begin
      pref_d = pref_after_grant(gnt);
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt[PORT_CPU] && gnt[PORT_AUX]));
  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~req) == '0);

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares a 1-cycle registered ROM between two readers: grant, address mux with idle hold, rvalid pipe.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIXED_PRIO = ARB_RR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  rom_read_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  gnt;
  logic [NUM_PORTS-1:0]  rvalid_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;

  assign req[PORT_CPU] = bus.req0;
  assign req[PORT_AUX] = bus.req1;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .gnt   (gnt)
  );

  // Idle cycles repeat the last granted address so the ROM input does not toggle.
  always_comb begin
    rom_addr = last_addr_q;
    if (gnt[PORT_CPU]) begin
      rom_addr = bus.addr0;
    end else if (gnt[PORT_AUX]) begin
      rom_addr = bus.addr1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q <= '0;
    end else if (|gnt) begin
      last_addr_q <= rom_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt;
    end
  end

  assign bus.gnt0    = gnt[PORT_CPU];
  assign bus.gnt1    = gnt[PORT_AUX];
  assign bus.rvalid0 = rvalid_q[PORT_CPU];
  assign bus.rvalid1 = rvalid_q[PORT_AUX];
  assign bus.rdata0  = rom_dout;
  assign bus.rdata1  = rom_dout;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances, each with its own behavioural ROM.
module tb_rom_read_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en_s   [2];
  logic [1:0] req_s  [2];
  logic [7:0] addr_s [2][2];

  logic [7:0] rom_mem [256];
  logic [7:0] rom_addr_rr, rom_addr_fx;
  logic [7:0] rom_dout_rr, rom_dout_fx;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state per instance: last granted port, held address, grants issued this cycle.
  int unsigned last_gnt_m  [2];
  logic [7:0]  last_addr_m [2];
  logic [1:0]  gnt_m       [2];
  logic [7:0]  exp_q [4][$];

  rom_read_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if_rr ();
  rom_read_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if_fx ();

  assign if_rr.req0  = req_s[0][0];
  assign if_rr.req1  = req_s[0][1];
  assign if_rr.addr0 = addr_s[0][0];
  assign if_rr.addr1 = addr_s[0][1];
  assign if_fx.req0  = req_s[1][0];
  assign if_fx.req1  = req_s[1][1];
  assign if_fx.addr0 = addr_s[1][0];
  assign if_fx.addr1 = addr_s[1][1];

  rom_read_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIXED_PRIO(0)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_s[0]),
    .bus      (if_rr),
    .rom_addr (rom_addr_rr),
    .rom_dout (rom_dout_rr)
  );

  rom_read_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIXED_PRIO(1)) u_fx (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_s[1]),
    .bus      (if_fx),
    .rom_addr (rom_addr_fx),
    .rom_dout (rom_dout_fx)
  );

  always @(posedge clk) rom_dout_rr <= rom_mem[rom_addr_rr];
  always @(posedge clk) rom_dout_fx <= rom_mem[rom_addr_fx];

  function automatic logic [1:0] dut_gnt(input int m);
    return (m == 0) ? {if_rr.gnt1, if_rr.gnt0} : {if_fx.gnt1, if_fx.gnt0};
  endfunction

  function automatic logic [1:0] dut_rv(input int m);
    return (m == 0) ? {if_rr.rvalid1, if_rr.rvalid0} : {if_fx.rvalid1, if_fx.rvalid0};
  endfunction

  function automatic logic [7:0] dut_rdata(input int m, input int p);
    if (m == 0) return (p == 0) ? if_rr.rdata0 : if_rr.rdata1;
    return (p == 0) ? if_fx.rdata0 : if_fx.rdata1;
  endfunction

  function automatic logic [7:0] dut_rom_addr(input int m);
    return (m == 0) ? rom_addr_rr : rom_addr_fx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instance 1 is fixed-priority; instance 0 gives ties to whichever port did not win last.
  function automatic logic [1:0] model_grant(input int m);
    if (!en_s[m] || req_s[m] == 2'b00) return 2'b00;
    if (req_s[m] == 2'b01) return 2'b01;
    if (req_s[m] == 2'b10) return 2'b10;
    if (m == 1) return 2'b01;
    return (last_gnt_m[m] == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      last_gnt_m[m]  = 1;
      last_addr_m[m] = 8'h00;
      gnt_m[m]       = 2'b00;
    end
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  // Called right after inputs change on a falling edge; ends on the next falling edge.
  task automatic tick();
    logic [1:0] eg;
    logic [7:0] ea;
    #1;
    for (int m = 0; m < 2; m++) begin
      eg = model_grant(m);
      check($sformatf("gnt inst%0d", m), {30'd0, dut_gnt(m)}, {30'd0, eg});
      ea = eg[0] ? addr_s[m][0] : (eg[1] ? addr_s[m][1] : last_addr_m[m]);
      check($sformatf("rom_addr inst%0d", m), {24'd0, dut_rom_addr(m)}, {24'd0, ea});
      for (int p = 0; p < 2; p++)
        if (eg[p]) exp_q[m*2+p].push_back(rom_mem[addr_s[m][p]]);
      if (|eg) begin
        last_gnt_m[m]  = eg[1] ? 1 : 0;
        last_addr_m[m] = ea;
      end
      gnt_m[m] = eg;
    end
    @(negedge clk);
  endtask

  task automatic set_all(input logic e, input logic [1:0] r, input logic [7:0] a0, input logic [7:0] a1);
    for (int m = 0; m < 2; m++) begin
      en_s[m]      = e;
      req_s[m]     = r;
      addr_s[m][0] = a0;
      addr_s[m][1] = a1;
    end
  endtask

  // Honours the requester contract: hold until granted, occasional withdrawal.
  task automatic rand_stim();
    for (int m = 0; m < 2; m++) begin
      en_s[m] = ($urandom % 10) != 0;
      for (int p = 0; p < 2; p++) begin
        if (gnt_m[m][p] || !req_s[m][p]) begin
          req_s[m][p]  = ($urandom % 10) < 7;
          addr_s[m][p] = 8'($urandom);
        end else if (($urandom % 16) == 0) begin
          req_s[m][p] = 1'b0;
        end
      end
    end
  endtask

  // Monitor: every rvalid must match a pending expected read, and data must match it.
  always @(posedge clk) begin
    logic [1:0] rv;
    logic [7:0] d;
    #1;
    for (int m = 0; m < 2; m++) begin
      rv = dut_rv(m);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rvalid%0d inst%0d", p, m), {31'd0, rv[p]},
              {31'd0, (exp_q[m*2+p].size() != 0)});
        if (exp_q[m*2+p].size() != 0) begin
          d = exp_q[m*2+p].pop_front();
          if (rv[p]) check($sformatf("rdata%0d inst%0d", p, m), {24'd0, dut_rdata(m, p)}, {24'd0, d});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    model_reset();
    set_all(1'b1, 2'b11, 8'h5A, 8'hA5);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("reset gnt inst%0d", m), {30'd0, dut_gnt(m)}, 32'd0);
      check($sformatf("reset rvalid inst%0d", m), {30'd0, dut_rv(m)}, 32'd0);
      check($sformatf("reset rom_addr inst%0d", m), {24'd0, dut_rom_addr(m)}, 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_all(1'b1, 2'b00, 8'h00, 8'h00);
    tick();

    set_all(1'b1, 2'b01, 8'hFF, 8'h00);
    tick();
    set_all(1'b1, 2'b00, 8'hFF, 8'h00);
    tick();

    set_all(1'b1, 2'b11, 8'h00, 8'h10);
    repeat (4) tick();
    set_all(1'b1, 2'b00, 8'h00, 8'h10);
    tick();

    set_all(1'b1, 2'b11, 8'h21, 8'h42);
    repeat (3) tick();
    set_all(1'b1, 2'b10, 8'h21, 8'h42);
    tick();
    set_all(1'b1, 2'b00, 8'h21, 8'h42);
    tick();

    set_all(1'b1, 2'b11, 8'h33, 8'h44);
    tick();
    set_all(1'b0, 2'b11, 8'h33, 8'h44);
    tick();
    set_all(1'b1, 2'b11, 8'h33, 8'h44);
    repeat (2) tick();
    set_all(1'b1, 2'b00, 8'h33, 8'h44);
    tick();

    // Reset pulsed after the read launched by gnt1 has produced its rvalid edge.
    set_all(1'b1, 2'b10, 8'h00, 8'hC3);
    tick();
    set_all(1'b1, 2'b11, 8'h77, 8'hC3);
    #1 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("midreset rvalid inst%0d", m), {30'd0, dut_rv(m)}, 32'd0);
      check($sformatf("midreset gnt inst%0d", m), {30'd0, dut_gnt(m)}, 32'd0);
      check($sformatf("midreset rom_addr inst%0d", m), {24'd0, dut_rom_addr(m)}, 32'd0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    for (int n = 0; n < 600; n++) begin
      rand_stim();
      tick();
    end

    set_all(1'b1, 2'b00, 8'h00, 8'h00);
    repeat (3) tick();
    for (int i = 0; i < 4; i++)
      check($sformatf("drain queue %0d", i), exp_q[i].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
